main_decode_pipe: RTL and testbench

MAIN_DECODE_PIPE -- requirements
Module: main_decode_pipe

---
 rtl/main_decode_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_main_decode_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_decode_pipe.sv
// RV32 main-control decoder feeding a 1- or 2-stage valid/ready pipeline with
// stall, flush and a saturating count of accepted illegal instructions.
module main_decode_pipe #(
  parameter int LATENCY  = 1,
  parameter bit ENABLE_U = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             regWrite,
  output logic             memWrite,
  output logic             aluSrc,
  output logic             aluASrcPc,
  output logic [2:0]       immSrc,
  output logic [1:0]       resultSrc,
  output logic             Branch,
  output logic             jumpSrc,
  output logic             jalrSrc,
  output logic [1:0]       aluOp,
  output logic [2:0]       sizeSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int LAST = LATENCY - 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       alu_a_src_pc;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       branch;
    logic       jump_src;
    logic       jalr_src;
    logic [1:0] alu_op;
    logic [2:0] size_src;
    logic       illegal;
  } ctrl_t;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       unused_instr;

  assign op           = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  ctrl_t dec;
  logic  legal;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dec   = '0;
    legal = 1'b1;
    case (op)
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jump_src   = 1'b1;
        dec.imm_src    = 3'b011;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jump_src   = 1'b1;
        dec.jalr_src   = 1'b1;
        legal          = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = 3'b010;
        dec.alu_op  = 2'b01;
        legal       = (funct3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.size_src   = funct3;
        legal          = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
        dec.size_src  = funct3;
        legal         = (funct3 <= 3'b010);
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.imm_src    = 3'b100;
        dec.result_src = 2'b11;
        legal          = ENABLE_U;
      end
      OP_AUIPC: begin
        dec.reg_write    = 1'b1;
        dec.alu_src      = 1'b1;
        dec.alu_a_src_pc = 1'b1;
        dec.imm_src      = 3'b100;
        legal            = ENABLE_U;
      end
      default: legal = 1'b0;
    endcase
    // An illegal instruction carries only the illegal flag downstream.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  logic [LATENCY-1:0] valid;
  logic [LATENCY-1:0] adv;
  logic [LATENCY-1:0] load;
  ctrl_t              data [LATENCY];
  logic               accept;

  // Advance is resolved from the output end backwards so a full pipe can
  // still move every cycle while the consumer is taking data.
  always_comb begin
    adv       = '0;
    adv[LAST] = valid[LAST] && out_ready && !stall;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = valid[i] && !stall && (!valid[i+1] || adv[i+1]);
    end
  end

  assign in_ready = !stall && !flush && (!valid[0] || adv[0]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      valid <= load | (valid & ~adv);
    end
  end

  // NOTE: payload registers carry no reset; they are only observed through a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (load[0]) data[0] <= dec;
    for (int i = 1; i < LATENCY; i++) begin
      if (load[i]) data[i] <= data[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (accept && dec.illegal && illegal_count != {CNT_W{1'b1}}) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  ctrl_t out_ctrl;

  assign out_valid = valid[LAST];
  assign out_ctrl  = valid[LAST] ? data[LAST] : '0;

  assign regWrite  = out_ctrl.reg_write;
  assign memWrite  = out_ctrl.mem_write;
  assign aluSrc    = out_ctrl.alu_src;
  assign aluASrcPc = out_ctrl.alu_a_src_pc;
  assign immSrc    = out_ctrl.imm_src;
  assign resultSrc = out_ctrl.result_src;
  assign Branch    = out_ctrl.branch;
  assign jumpSrc   = out_ctrl.jump_src;
  assign jalrSrc   = out_ctrl.jalr_src;
  assign aluOp     = out_ctrl.alu_op;
  assign sizeSrc   = out_ctrl.size_src;
  assign illegal   = out_ctrl.illegal;

endmodule

// File: tb/tb_main_decode_pipe.sv
// Bench for main_decode_pipe: two instances (LATENCY=1/ENABLE_U=1/CNT_W=8 and
// LATENCY=2/ENABLE_U=0/CNT_W=2) share one stimulus stream; a scoreboard per instance.
module tb_main_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        out_ready;

  always #5 clk = ~clk;

  logic       in_ready_a, out_valid_a, regWrite_a, memWrite_a, aluSrc_a, aluASrcPc_a;
  logic       Branch_a, jumpSrc_a, jalrSrc_a, illegal_a;
  logic [2:0] immSrc_a, sizeSrc_a;
  logic [1:0] resultSrc_a, aluOp_a;
  logic [7:0] illegal_count_a;

  logic       in_ready_b, out_valid_b, regWrite_b, memWrite_b, aluSrc_b, aluASrcPc_b;
  logic       Branch_b, jumpSrc_b, jalrSrc_b, illegal_b;
  logic [2:0] immSrc_b, sizeSrc_b;
  logic [1:0] resultSrc_b, aluOp_b;
  logic [1:0] illegal_count_b;

  main_decode_pipe #(.LATENCY(1), .ENABLE_U(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .regWrite(regWrite_a), .memWrite(memWrite_a), .aluSrc(aluSrc_a), .aluASrcPc(aluASrcPc_a),
    .immSrc(immSrc_a), .resultSrc(resultSrc_a), .Branch(Branch_a), .jumpSrc(jumpSrc_a),
    .jalrSrc(jalrSrc_a), .aluOp(aluOp_a), .sizeSrc(sizeSrc_a), .illegal(illegal_a),
    .illegal_count(illegal_count_a)
  );

  main_decode_pipe #(.LATENCY(2), .ENABLE_U(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .instr(instr),
    .stall(stall), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .regWrite(regWrite_b), .memWrite(memWrite_b), .aluSrc(aluSrc_b), .aluASrcPc(aluASrcPc_b),
    .immSrc(immSrc_b), .resultSrc(resultSrc_b), .Branch(Branch_b), .jumpSrc(jumpSrc_b),
    .jalrSrc(jalrSrc_b), .aluOp(aluOp_b), .sizeSrc(sizeSrc_b), .illegal(illegal_b),
    .illegal_count(illegal_count_b)
  );

  // Bundle packing: {rw, mw, as, pc, imm[3], rs[2], br, js, jr, aluop[2], size[3], ill}
  logic [17:0] obs_a, obs_b;
  assign obs_a = {regWrite_a, memWrite_a, aluSrc_a, aluASrcPc_a, immSrc_a, resultSrc_a,
                  Branch_a, jumpSrc_a, jalrSrc_a, aluOp_a, sizeSrc_a, illegal_a};
  assign obs_b = {regWrite_b, memWrite_b, aluSrc_b, aluASrcPc_b, immSrc_b, resultSrc_b,
                  Branch_b, jumpSrc_b, jalrSrc_b, aluOp_b, sizeSrc_b, illegal_b};

  localparam logic [31:0] ADDI  = 32'h00A00093;
  localparam logic [31:0] LW    = 32'h0002A303;
  localparam logic [31:0] SW    = 32'h0062A023;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] LUI   = 32'h000012B7;
  localparam logic [31:0] AUIPC = 32'h00000297;
  localparam logic [31:0] BADOP = 32'h0000007F;

  logic [31:0] tbl [0:16] = '{ADDI, LW, SW, JAL, LUI, AUIPC, BADOP,
                              32'h000080E7, 32'h000010E7, 32'h00000063, 32'h00004063,
                              32'h00003063, 32'h002081B3, 32'h0000C003, 32'h00006003,
                              32'h00001023, 32'h00000000};

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [17:0] model(input logic [31:0] ins, input bit en_u);
    logic [2:0]  f3;
    logic [17:0] ill;
    f3  = ins[14:12];
    ill = 18'd1;
    case (ins[6:0])
      7'b1101111: return 18'b1010_011_10_010_00_000_0;
      7'b1100111: return (f3 == 3'd0) ? 18'b1010_000_10_011_00_000_0 : ill;
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? ill : 18'b0000_010_00_100_01_000_0;
      7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? ill
                         : {14'b1010_000_01_000_00, f3, 1'b0};
      7'b0100011: return (f3 > 3'd2) ? ill : {14'b0110_001_00_000_00, f3, 1'b0};
      7'b0010011: return 18'b1010_000_00_000_10_000_0;
      7'b0110011: return 18'b1000_000_00_000_10_000_0;
      7'b0110111: return en_u ? 18'b1000_100_11_000_00_000_0 : ill;
      7'b0010111: return en_u ? 18'b1011_100_00_000_00_000_0 : ill;
      default:    return ill;
    endcase
  endfunction

  logic [17:0] q_a[$], q_b[$];
  int          cnt_a_m, cnt_b_m;
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [17:0] held_a, held_b, e_a, e_b;

  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      cnt_a_m = 0;
      hold_a  = 1'b0;
      check("rst_out_a", {out_valid_a, obs_a}, 32'd0);
      check("rst_cnt_a", illegal_count_a, 32'd0);
    end else begin
      check("count_a", illegal_count_a, cnt_a_m);
      if (hold_a) check("hold_a", {out_valid_a, obs_a}, {1'b1, held_a});
      if (!out_valid_a) check("idle_zero_a", obs_a, 32'd0);
      else if (q_a.size() == 0) check("spurious_a", out_valid_a, 32'd0);
      else check("data_a", obs_a, q_a[0]);
      hold_a = out_valid_a && (!out_ready || stall) && !flush;
      held_a = obs_a;
      if (out_valid_a && out_ready && !stall && !flush && q_a.size() > 0) void'(q_a.pop_front());
      if (flush) q_a.delete();
      if (in_valid && in_ready_a) begin
        e_a = model(instr, 1'b1);
        q_a.push_back(e_a);
        if (e_a[0] && cnt_a_m < 255) cnt_a_m++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q_b.delete();
      cnt_b_m = 0;
      hold_b  = 1'b0;
      check("rst_out_b", {out_valid_b, obs_b}, 32'd0);
      check("rst_cnt_b", illegal_count_b, 32'd0);
    end else begin
      check("count_b", illegal_count_b, cnt_b_m);
      if (hold_b) check("hold_b", {out_valid_b, obs_b}, {1'b1, held_b});
      if (!out_valid_b) check("idle_zero_b", obs_b, 32'd0);
      else if (q_b.size() == 0) check("spurious_b", out_valid_b, 32'd0);
      else check("data_b", obs_b, q_b[0]);
      hold_b = out_valid_b && (!out_ready || stall) && !flush;
      held_b = obs_b;
      if (out_valid_b && out_ready && !stall && !flush && q_b.size() > 0) void'(q_b.pop_front());
      if (flush) q_b.delete();
      if (in_valid && in_ready_b) begin
        e_b = model(instr, 1'b0);
        q_b.push_back(e_b);
        if (e_b[0] && cnt_b_m < 3) cnt_b_m++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("reset_valid_a", out_valid_a, 32'd0);
    check("reset_valid_b", out_valid_b, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset_a", in_ready_a, 32'd1);
    check("ready_after_reset_b", in_ready_b, 32'd1);

    // addi: one cycle to output on the single-stage pipe, two on the double
    step(); in_valid = 1'b1; instr = ADDI;
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("addi_valid_a", out_valid_a, 32'd1);
    check("addi_bundle_a", obs_a, 18'b1010_000_00_000_10_000_0);
    check("addi_early_b", out_valid_b, 32'd0);
    step();
    @(negedge clk);
    check("addi_gone_a", out_valid_a, 32'd0);
    check("addi_valid_b", out_valid_b, 32'd1);

    // back-to-back lw, sw, jal with the consumer always ready
    step(); in_valid = 1'b1; instr = LW;
    step(); instr = SW;
    @(negedge clk);
    check("lw_latency_b", out_valid_b, 32'd0);
    check("lw_valid_a", out_valid_a, 32'd1);
    check("throughput_a", in_ready_a, 32'd1);
    step(); instr = JAL;
    @(negedge clk);
    check("lw_valid_b", out_valid_b, 32'd1);
    check("lw_result_b", resultSrc_b, 32'b01);
    check("lw_size_b", sizeSrc_b, 32'b010);
    check("throughput_b", in_ready_b, 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("sw_mem_b", memWrite_b, 32'd1);
    check("sw_imm_b", immSrc_b, 32'b001);
    step();
    @(negedge clk);
    check("jal_jump_b", jumpSrc_b, 32'd1);
    check("jal_result_b", resultSrc_b, 32'b10);
    check("jal_imm_b", immSrc_b, 32'b011);
    step();
    @(negedge clk);
    check("seq_done_b", out_valid_b, 32'd0);

    // backpressure with a full pipe, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); in_valid = 1'b1; instr = tbl[i % 4];
      @(negedge clk);
      if (i >= 1) check("bp_ready_a", in_ready_a, 32'd0);
      if (i >= 2) check("bp_ready_b", in_ready_b, 32'd0);
    end
    step(); in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check("bp_drained_a", q_a.size(), 32'd0);
    check("bp_drained_b", q_b.size(), 32'd0);
    check("bp_idle_b", out_valid_b, 32'd0);

    // stall holds everything, then flush overrides stall with a pending beat
    step(); in_valid = 1'b1; instr = AUIPC;
    step(); instr = LUI;
    step(); in_valid = 1'b0; stall = 1'b1;
    @(negedge clk);
    check("stall_ready_a", in_ready_a, 32'd0);
    check("stall_ready_b", in_ready_b, 32'd0);
    check("stall_valid_b", out_valid_b, 32'd1);
    step();
    @(negedge clk);
    check("stall_hold_a", out_valid_a, 32'd1);
    check("stall_hold_b", out_valid_b, 32'd1);
    step(); flush = 1'b1; in_valid = 1'b1; instr = BADOP;
    step(); flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_a", out_valid_a, 32'd0);
    check("flush_valid_b", out_valid_b, 32'd0);
    check("flush_count_a", illegal_count_a, 32'd0);
    check("flush_count_b", illegal_count_b, 32'd2);

    // reset in the middle of a stream
    step(); in_valid = 1'b1; instr = ADDI;
    step(); instr = LW;
    step(); instr = SW;
    @(negedge clk);
    check("pre_rst_valid_b", out_valid_b, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_a", {out_valid_a, obs_a}, 32'd0);
    check("rst_async_b", {out_valid_b, obs_b}, 32'd0);
    check("rst_async_cnt_b", illegal_count_b, 32'd0);
    step();
    step(); rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_a", out_valid_a, 32'd0);
      check("post_rst_b", out_valid_b, 32'd0);
      step();
    end

    // illegal encodings and counter saturation on the 2-bit counter
    step(); in_valid = 1'b1; instr = BADOP;
    step(); instr = 32'h00003003;
    step(); instr = LUI;
    @(negedge clk);
    check("ill_op_b", {out_valid_b, obs_b}, {1'b1, 18'd1});
    step(); in_valid = 1'b0;
    @(negedge clk);
    check("ill_count_a", illegal_count_a, 32'd2);
    check("ill_count_b", illegal_count_b, 32'd3);
    check("lui_legal_a", {out_valid_a, obs_a}, {1'b1, 18'b1000_100_11_000_00_000_0});
    step();
    @(negedge clk);
    check("lui_illegal_b", {out_valid_b, obs_b}, {1'b1, 18'd1});
    step(); in_valid = 1'b1; instr = 32'h00003023;
    step(); instr = 32'h00002063;
    step(); in_valid = 1'b0;
    step();
    @(negedge clk);
    check("sat_count_a", illegal_count_a, 32'd4);
    check("sat_count_b", illegal_count_b, 32'd3);

    // mixed traffic with random gaps, backpressure, stalls and flushes
    for (int i = 0; i < 120; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = tbl[$urandom_range(0, 16)];
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
    step(); in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("final_empty_a", q_a.size(), 32'd0);
    check("final_empty_b", q_b.size(), 32'd0);
    check("final_idle_a", out_valid_a, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
